mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one synchronous single-port memory between the control unit's memory port (MAR/MBR path, rnw, WMFC/MFC handshake) and an I/O/DMA requester.
- Sequences each access with a programmable number of wait states.
- Returns a one-cycle completion pulse to the winner. For the CPU, this pulse is MFC, which releases the WMFC-gated control clock for exactly one edge.

Parameters:
- AW, 8, address width
- DW, 8, data width
- WAIT, 2, extra wait cycles per access (0 allowed); counter width max(1, clog2(WAIT+1))

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- cpu_req  input  1  CPU access request; held high until cpu_mfc is seen
- cpu_rnw  input  1  1 = read, 0 = write
- cpu_addr  input  AW  CPU address (MAR)
- cpu_wdata  input  DW  CPU write data (MBR)
- cpu_rdata  output  DW  CPU read data
- cpu_mfc  output  1  memory-function-complete pulse to CPU
- io_req  input  1  I/O request; same rules as cpu_req
- io_rnw  input  1  1 = read, 0 = write
- io_addr  input  AW  I/O address
- io_wdata  input  DW  I/O write data
- io_rdata  output  DW  I/O read data
- io_done  output  1  completion pulse to I/O
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid in the cycle after mem_en with we = 0
- busy  output  1  high whenever state != IDLE
- grant_io  output  1  0 = CPU owns the current access, 1 = I/O owns it

Behaviour:
- All outputs are registered. Reset (reset_n = 0 at an edge) forces:
  - state IDLE, last_served = IO (so the CPU wins the first tie)
  - mem_en, mem_we, cpu_mfc, io_done, busy, grant_io = 0
  - mem_addr, mem_wdata, cpu_rdata, io_rdata = 0
- Reset mid-access aborts it:
  - no done pulse is issued
  - mem_en/mem_we are low from the cycle after the reset edge
  - a partially written location is not guaranteed
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not equal to last_served.
  - On grant:
    - latch rnw, addr and wdata into mem_addr/mem_wdata
    - mem_en = 1, mem_we = !rnw, grant_io = winner
    - counter = WAIT, next state ACCESS
- ACCESS:
  - mem_en is held 1; the address, data and we are stable for the whole access.
  - If counter != 0: decrement and stay in ACCESS.
  - If counter == 0:
    - on a read, capture mem_rdata into the winner's rdata register (the other requester's rdata is unchanged)
    - drop mem_en and mem_we
    - raise the winner's done pulse
    - update last_served to the winner
    - next state DONE
- DONE:
  - cpu_mfc or io_done is high for exactly this one cycle.
  - Next state IDLE, pulse cleared.
  - The IDLE cycle after DONE arbitrates fresh; a requester dropping req after seeing done is not re-granted.
- Latency: the grant edge is followed by WAIT+1 cycles in ACCESS, then one DONE cycle. The done pulse goes high WAIT+1 edges after the grant edge.
- rdata registers hold their value until the same requester's next read completes.
- Write accesses never modify rdata.
- Fairness: under continuous contention, grants alternate strictly, so each requester waits at most one foreign access.
- A request arriving while busy waits; it is never dropped.
- If req is withdrawn mid-access, the access still completes and the done pulse still fires.
- Address and data carry no arithmetic; wrap-around is the memory's concern.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE}
  - requester IDs REQ_CPU = 0, REQ_IO = 1
- Sub-module rr_arb2:
  - purely combinational 2-way round-robin pick from (cpu_req, io_req, last_served)
  - outputs gnt_valid and gnt_id
- FSM, wait counter and datapath registers live in mem_arbiter.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with both reqs high -> all outputs 0, busy 0; after release the CPU is granted first (grant_io = 0).
- CPU read, WAIT = 2: mem holds 0x5A at 0x10, cpu_req/rnw = 1, addr 0x10 -> mem_en high 3 cycles, cpu_mfc one-cycle pulse 3 edges after the grant edge, cpu_rdata = 0x5A, io_rdata unchanged.
- I/O write then CPU read of the same address: io writes 0x3C to 0x20 -> mem_we high for the whole access, io_done pulses once; a following CPU read of 0x20 returns 0x3C.
- Contention: both reqs held for 4 accesses -> grant order CPU, IO, CPU, IO; exactly one done pulse per access; no overlap of mem_en between accesses.
- Reset mid-access: assert reset_n = 0 in the second ACCESS cycle -> mem_en = 0 next cycle, no cpu_mfc/io_done pulse, state IDLE.
- WAIT = 0 build: a single CPU read -> ACCESS lasts 1 cycle, cpu_mfc high on the edge after the grant edge, busy high for exactly 2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : mem_arb_pkg                                               |
// | Purpose: Shared types and constants for the memory arbiter: FSM    |
// |          state encoding, requester IDs and a counter-width helper. |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IO  = 1'b1;

   // Width of the wait-state counter; at least one bit even when no
   // wait states are configured.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : mem_arbiter_if                                            |
// | Purpose: Bundles the CPU port, the I/O port, the memory port and   |
// |          the status outputs of the memory arbiter.                 |
// | Ports  : slave  - arbiter view (takes requests, drives memory)     |
// |          master - environment view (requesters + memory)           |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   // CPU memory port (MAR/MBR, WMFC/MFC handshake)
   logic          cpu_req;
   logic          cpu_rnw;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_mfc;
   // I/O / DMA port
   logic          io_req;
   logic          io_rnw;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_wdata;
   logic [DW-1:0] io_rdata;
   logic          io_done;
   // Single-port synchronous memory
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   // Status
   logic          busy;
   logic          grant_io;

   modport slave (
      input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
      input  io_req, io_rnw, io_addr, io_wdata,
      input  mem_rdata,
      output cpu_rdata, cpu_mfc, io_rdata, io_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, grant_io
   );

   modport master (
      output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
      output io_req, io_rnw, io_addr, io_wdata,
      output mem_rdata,
      input  cpu_rdata, cpu_mfc, io_rdata, io_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, grant_io
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : rr_arb2                                                   |
// | Purpose: Combinational two-way round-robin pick between the CPU    |
// |          and I/O requesters.                                       |
// | Ports  : cpu_req, io_req - pending requests                        |
// |          last_served     - ID of the most recent winner            |
// |          gnt_valid       - at least one request pending            |
// |          gnt_id          - winning requester ID                    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic io_req,
   input  logic last_served,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = cpu_req | io_req;
      if (cpu_req && io_req) begin
         // Contention: the side that was not served last goes next.
         gnt_id = ~last_served;
      end else if (io_req) begin
         gnt_id = REQ_IO;
      end else begin
         gnt_id = REQ_CPU;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : mem_arbiter                                               |
// | Purpose: Shares one synchronous single-port memory between the     |
// |          CPU memory port and an I/O/DMA requester. Each access     |
// |          holds the memory for WAIT+1 cycles, then returns a        |
// |          one-cycle completion pulse (cpu_mfc / io_done).           |
// | Ports  : CLK     - system clock, rising edge                       |
// |          reset_n - synchronous active-low reset                    |
// |          bus     - requester, memory and status signals            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int WAIT = 2
) (
   input  logic          CLK,
   input  logic          reset_n,
   mem_arbiter_if.slave  bus
);

   localparam int            CW        = cnt_width(WAIT);
   localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          last_served;
   logic          acc_rnw;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] cpu_rdata;
   logic [DW-1:0] io_rdata;
   logic          cpu_mfc;
   logic          io_done;
   logic          busy;
   logic          grant_io;

   logic          gnt_valid;
   logic          gnt_id;

   rr_arb2 u_rr_arb2 (
      .cpu_req     (bus.cpu_req),
      .io_req      (bus.io_req),
      .last_served (last_served),
      .gnt_valid   (gnt_valid),
      .gnt_id      (gnt_id)
   );

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         last_served <= REQ_IO;      // CPU wins the first tie
         acc_rnw     <= 1'b1;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_rdata   <= '0;
         io_rdata    <= '0;
         cpu_mfc     <= 1'b0;
         io_done     <= 1'b0;
         busy        <= 1'b0;
         grant_io    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  // Latch the winner's request so it stays stable for the
                  // whole access even if the requester changes its inputs.
                  if (gnt_id == REQ_IO) begin
                     acc_rnw   <= bus.io_rnw;
                     mem_we    <= ~bus.io_rnw;
                     mem_addr  <= bus.io_addr;
                     mem_wdata <= bus.io_wdata;
                  end else begin
                     acc_rnw   <= bus.cpu_rnw;
                     mem_we    <= ~bus.cpu_rnw;
                     mem_addr  <= bus.cpu_addr;
                     mem_wdata <= bus.cpu_wdata;
                  end
                  grant_io <= gnt_id;
                  mem_en   <= 1'b1;
                  busy     <= 1'b1;
                  wait_cnt <= WAIT_INIT;
                  state    <= ACCESS;
               end
            end

            ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else begin
                  if (acc_rnw) begin
                     if (grant_io == REQ_IO) begin
                        io_rdata <= bus.mem_rdata;
                     end else begin
                        cpu_rdata <= bus.mem_rdata;
                     end
                  end
                  mem_en      <= 1'b0;
                  mem_we      <= 1'b0;
                  cpu_mfc     <= (grant_io == REQ_CPU);
                  io_done     <= (grant_io == REQ_IO);
                  last_served <= grant_io;
                  state       <= DONE;
               end
            end

            DONE: begin
               cpu_mfc <= 1'b0;
               io_done <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.cpu_rdata = cpu_rdata;
   assign bus.io_rdata  = io_rdata;
   assign bus.cpu_mfc   = cpu_mfc;
   assign bus.io_done   = io_done;
   assign bus.busy      = busy;
   assign bus.grant_io  = grant_io;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : tb_mem_arbiter                                            |
// | Purpose: Self-checking bench for mem_arbiter (WAIT=2 main instance |
// |          plus a WAIT=0 instance for latency corner cases).         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int WAIT = 2;

   logic CLK = 1'b0;
   logic reset_n;
   always #5 CLK = ~CLK;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

   mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus0.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] fill_val(input int i);
      return 8'(i * 37 + 11);
   endfunction

   // ---------------- synchronous single-port memory model ----------------
   logic [7:0] mem [256];
   logic       bk_fill = 1'b0;
   logic       bk_we   = 1'b0;
   logic [7:0] bk_addr = 8'h00;
   logic [7:0] bk_data = 8'h00;

   always @(posedge CLK) begin
      if (bk_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= fill_val(i);
      end else if (bk_we) begin
         mem[bk_addr] <= bk_data;
      end else if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   assign bus0.mem_rdata = 8'hC3;

   // ---------------- transaction-level reference model / monitor ----------------
   logic       p_rst, p_busy, p_creq, p_ireq, p_crnw, p_irnw, p_fill, p_bkwe;
   logic [7:0] p_caddr, p_cwd, p_iaddr, p_iwd, p_bka, p_bkd;
   logic       m_active = 1'b0;
   int         m_k = 0;
   logic       m_win, m_rnw, exp_w;
   logic [7:0] m_addr, m_wdata;
   logic       last_win = 1'b1;
   logic [7:0] ref_mem [256];
   logic [7:0] exp_cpu_rd = 8'h00;
   logic [7:0] exp_io_rd  = 8'h00;
   int         fw_cpu = 0;
   int         fw_io  = 0;
   int         n_done = 0;
   logic       done_order [1024];

   always begin
      @(posedge CLK);
      p_rst  = reset_n;      p_busy  = bus.busy;
      p_creq = bus.cpu_req;  p_ireq  = bus.io_req;
      p_crnw = bus.cpu_rnw;  p_caddr = bus.cpu_addr; p_cwd = bus.cpu_wdata;
      p_irnw = bus.io_rnw;   p_iaddr = bus.io_addr;  p_iwd = bus.io_wdata;
      p_fill = bk_fill;      p_bkwe  = bk_we; p_bka = bk_addr; p_bkd = bk_data;
      #1;
      if (p_fill) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = fill_val(i);
      end else if (p_bkwe) begin
         ref_mem[p_bka] = p_bkd;
      end

      if (!p_rst) begin
         m_active = 1'b0; last_win = 1'b1;
         exp_cpu_rd = 8'h00; exp_io_rd = 8'h00; fw_cpu = 0; fw_io = 0;
         chk("rst_busy",      bus.busy,      0);
         chk("rst_grant_io",  bus.grant_io,  0);
         chk("rst_mem_en",    bus.mem_en,    0);
         chk("rst_mem_we",    bus.mem_we,    0);
         chk("rst_cpu_mfc",   bus.cpu_mfc,   0);
         chk("rst_io_done",   bus.io_done,   0);
         chk("rst_mem_addr",  bus.mem_addr,  0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
         chk("rst_cpu_rdata", bus.cpu_rdata, 0);
         chk("rst_io_rdata",  bus.io_rdata,  0);
      end else if (m_active) begin
         m_k++;
         if (m_k <= WAIT) begin
            chk("acc_mem_en",  bus.mem_en,   1);
            chk("acc_mem_we",  bus.mem_we,   !m_rnw);
            chk("acc_addr",    bus.mem_addr, m_addr);
            if (!m_rnw) chk("acc_wdata", bus.mem_wdata, m_wdata);
            chk("acc_busy",    bus.busy,     1);
            chk("acc_no_done", {bus.cpu_mfc, bus.io_done}, 0);
         end else if (m_k == WAIT + 1) begin
            chk("done_mem_en", bus.mem_en,  0);
            chk("done_mem_we", bus.mem_we,  0);
            chk("done_busy",   bus.busy,    1);
            chk("done_cpu_mfc", bus.cpu_mfc, !m_win);
            chk("done_io_done", bus.io_done, m_win);
            if (m_rnw) begin
               if (m_win) exp_io_rd  = ref_mem[m_addr];
               else       exp_cpu_rd = ref_mem[m_addr];
            end else begin
               ref_mem[m_addr] = m_wdata;
            end
            chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
            chk("io_rdata",  bus.io_rdata,  exp_io_rd);
            // Each requester may see at most one foreign access while waiting.
            if (m_win) begin
               chk("io_fair_wait", fw_io <= 1, 1);
               fw_io = 0;
               if (p_creq) fw_cpu++;
            end else begin
               chk("cpu_fair_wait", fw_cpu <= 1, 1);
               fw_cpu = 0;
               if (p_ireq) fw_io++;
            end
            last_win = m_win;
            if (n_done < 1024) done_order[n_done] = m_win;
            n_done++;
         end else begin
            chk("post_busy",   bus.busy,   0);
            chk("post_mem_en", bus.mem_en, 0);
            chk("post_done",   {bus.cpu_mfc, bus.io_done}, 0);
            m_active = 1'b0;
         end
      end else if (!p_busy && (p_creq || p_ireq)) begin
         exp_w   = (p_creq && p_ireq) ? ~last_win : p_ireq;
         m_win   = exp_w;
         m_rnw   = exp_w ? p_irnw  : p_crnw;
         m_addr  = exp_w ? p_iaddr : p_caddr;
         m_wdata = exp_w ? p_iwd   : p_cwd;
         m_active = 1'b1;
         m_k = 0;
         chk("grant_id",     bus.grant_io, exp_w);
         chk("grant_busy",   bus.busy,     1);
         chk("grant_mem_en", bus.mem_en,   1);
         chk("grant_mem_we", bus.mem_we,   !m_rnw);
         chk("grant_addr",   bus.mem_addr, m_addr);
      end else begin
         chk("idle_busy",   bus.busy,   0);
         chk("idle_mem_en", bus.mem_en, 0);
         chk("idle_done",   {bus.cpu_mfc, bus.io_done}, 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bk_write(input logic [7:0] a, input logic [7:0] d);
      bk_addr = a; bk_data = d; bk_we = 1'b1;
      tick();
      bk_we = 1'b0;
   endtask

   // Hold pending requests until their completion pulse is seen.
   task automatic serve(input int limit);
      int n;
      n = 0;
      while ((bus.cpu_req || bus.io_req) && n < limit) begin
         tick();
         n++;
         if (bus.cpu_mfc) bus.cpu_req = 1'b0;
         if (bus.io_done) bus.io_req  = 1'b0;
      end
      if (bus.cpu_req || bus.io_req) begin
         checks++; failures++;
         $display("FAIL serve_timeout pending_cpu=%0d pending_io=%0d limit=%0d",
                  bus.cpu_req, bus.io_req, limit);
         bus.cpu_req = 1'b0; bus.io_req = 1'b0;
      end
   endtask

   task automatic issue(input logic who, input logic rnw, input logic [7:0] a, input logic [7:0] d);
      if (who) begin
         bus.io_rnw = rnw; bus.io_addr = a; bus.io_wdata = d; bus.io_req = 1'b1;
      end else begin
         bus.cpu_rnw = rnw; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
      end
      serve(40);
   endtask

   typedef struct packed {
      logic       who;      // 0 = CPU, 1 = I/O
      logic       rnw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vt [8];

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int   start;
      logic c_pend, i_pend;

      vt[0] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h5A};
      vt[1] = '{1'b1, 1'b0, 8'h20, 8'h3C, 8'h00};
      vt[2] = '{1'b0, 1'b1, 8'h20, 8'h00, 8'h3C};
      vt[3] = '{1'b1, 1'b1, 8'h10, 8'h00, 8'h5A};
      vt[4] = '{1'b0, 1'b0, 8'hFF, 8'h81, 8'h00};
      vt[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h81};
      vt[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h0B};
      vt[7] = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h30};

      // Reset held two cycles with both requests pending.
      reset_n = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h00;
      bus.io_req  = 1'b1; bus.io_rnw  = 1'b1; bus.io_addr  = 8'h11; bus.io_wdata  = 8'h00;
      bus0.cpu_req = 1'b0; bus0.cpu_rnw = 1'b1; bus0.cpu_addr = 8'h00; bus0.cpu_wdata = 8'h00;
      bus0.io_req  = 1'b0; bus0.io_rnw  = 1'b1; bus0.io_addr  = 8'h00; bus0.io_wdata  = 8'h00;
      bk_fill = 1'b1;
      tick();
      tick();
      bk_fill = 1'b0;
      chk("w0_rst_busy",   bus0.busy,    0);
      chk("w0_rst_mem_en", bus0.mem_en,  0);
      chk("w0_rst_mfc",    bus0.cpu_mfc, 0);
      reset_n = 1'b1;
      tick();
      chk("first_grant_cpu", bus.grant_io, 0);
      chk("first_grant_busy", bus.busy, 1);
      serve(40);

      // Table-driven single accesses.
      bk_write(8'h10, 8'h5A);
      for (int i = 0; i < 8; i++) begin
         issue(vt[i].who, vt[i].rnw, vt[i].addr, vt[i].wdata);
         if (vt[i].rnw) begin
            if (vt[i].who) chk($sformatf("vec%0d_io_rdata", i),  bus.io_rdata,  vt[i].exp_rd);
            else           chk($sformatf("vec%0d_cpu_rdata", i), bus.cpu_rdata, vt[i].exp_rd);
         end
      end

      // Contention after a fresh reset: CPU, IO, CPU, IO.
      reset_n = 1'b0;
      tick();
      tick();
      bus.cpu_rnw = 1'b1; bus.cpu_addr = 8'h05;
      bus.io_rnw  = 1'b1; bus.io_addr  = 8'h06;
      bus.cpu_req = 1'b1; bus.io_req = 1'b1;
      reset_n = 1'b1;
      start = n_done;
      for (int n = 0; n < 60 && (n_done - start) < 4; n++) tick();
      bus.cpu_req = 1'b0; bus.io_req = 1'b0;
      chk("contention_count", n_done - start, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("contention_order%0d", i), done_order[start + i], i % 2);
      repeat (4) tick();

      // Reset in the second ACCESS cycle of a CPU read.
      bus.cpu_rnw = 1'b1; bus.cpu_addr = 8'h33; bus.cpu_req = 1'b1;
      tick();
      chk("midrst_granted", bus.busy, 1);
      tick();
      reset_n = 1'b0; bus.cpu_req = 1'b0;
      tick();
      chk("midrst_mem_en", bus.mem_en,  0);
      chk("midrst_mfc",    bus.cpu_mfc, 0);
      chk("midrst_busy",   bus.busy,    0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("midrst_no_pulse", {bus.cpu_mfc, bus.io_done}, 0);
      end

      // WAIT = 0 instance: one CPU read.
      bus0.cpu_addr = 8'h44; bus0.cpu_rnw = 1'b1; bus0.cpu_req = 1'b1;
      tick();
      chk("w0_grant_en",   bus0.mem_en,  1);
      chk("w0_grant_busy", bus0.busy,    1);
      chk("w0_grant_mfc",  bus0.cpu_mfc, 0);
      tick();
      chk("w0_mfc",        bus0.cpu_mfc, 1);
      chk("w0_done_en",    bus0.mem_en,  0);
      chk("w0_done_busy",  bus0.busy,    1);
      chk("w0_rdata",      bus0.cpu_rdata, 8'hC3);
      bus0.cpu_req = 1'b0;
      tick();
      chk("w0_mfc_clear",  bus0.cpu_mfc, 0);
      chk("w0_idle_busy",  bus0.busy,    0);
      tick();
      chk("w0_stay_idle",  bus0.busy,    0);

      // Randomized traffic on the main instance.
      c_pend = 1'b0; i_pend = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         if (bus.cpu_mfc) c_pend = 1'b0;
         if (bus.io_done) i_pend = 1'b0;
         if (!c_pend && cyc < 1400 && $urandom_range(0, 2) == 0) begin
            c_pend = 1'b1;
            bus.cpu_rnw   = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 8'($urandom_range(0, 15));
            bus.cpu_wdata = 8'($urandom);
         end
         if (!i_pend && cyc < 1400 && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            bus.io_rnw   = 1'($urandom_range(0, 1));
            bus.io_addr  = 8'($urandom_range(0, 15));
            bus.io_wdata = 8'($urandom);
         end
         bus.cpu_req = c_pend;
         bus.io_req  = i_pend;
      end
      chk("random_drained", {c_pend, i_pend}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
